// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit seven-segment scanner.
// Holds the default timing dividers, the active-low segment fonts, the
// blank code and the one-cold digit-enable codes, plus two lookup helpers.
package fnd_pkg;

  localparam int SCAN_DIV_DEFAULT  = 100_000;
  localparam int BLINK_DIV_DEFAULT = 50_000_000;

  // Segment fonts, active-low, bit7 = dp (off), bits6..0 = g..a
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  // Digit enables, active-low one-cold; digit 0 = ones
  localparam logic [3:0] COM_D0  = 4'b1110;
  localparam logic [3:0] COM_D1  = 4'b1101;
  localparam logic [3:0] COM_D2  = 4'b1011;
  localparam logic [3:0] COM_D3  = 4'b0111;
  localparam logic [3:0] COM_OFF = 4'b1111;

  function automatic logic [7:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    return FONT_0;
      4'd1:    return FONT_1;
      4'd2:    return FONT_2;
      4'd3:    return FONT_3;
      4'd4:    return FONT_4;
      4'd5:    return FONT_5;
      4'd6:    return FONT_6;
      4'd7:    return FONT_7;
      4'd8:    return FONT_8;
      4'd9:    return FONT_9;
      default: return FONT_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] com_code(input logic [1:0] idx);
    case (idx)
      2'd0:    return COM_D0;
      2'd1:    return COM_D1;
      2'd2:    return COM_D2;
      default: return COM_D3;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, 14-bit binary -> 4 BCD digits.
// start (while idle) loads bin; 14 shift/add-3 cycles follow; done pulses
// for one cycle 15 cycles after start with the result on bcd, which holds
// until the next conversion completes. Starts while busy are ignored.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a conversion (ignored while busy)
//   bin[13:0]  : binary input, must be <= 9999
//   busy, done : conversion in progress / one-cycle completion pulse
//   bcd[15:0]  : {thousands, hundreds, tens, ones}
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  // {bcd[15:0], bin[13:0]} working register
  logic [29:0] sh_q, sh_d;
  logic [29:0] adj, shifted;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] bcd_q, bcd_d;

  always_comb begin
    adj = sh_q;
    for (int i = 0; i < 4; i++) begin
      if (sh_q[14+4*i +: 4] >= 4'd5) adj[14+4*i +: 4] = sh_q[14+4*i +: 4] + 4'd3;
    end
    shifted = adj << 1;

    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    bcd_d  = bcd_q;
    if (busy_q) begin
      sh_d  = shifted;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        bcd_d  = shifted[29:14];
      end
    end else if (start) begin
      sh_d   = {16'd0, bin};
      cnt_d  = 4'd14;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q  <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/fnd_scan.sv
// Multiplexed 4-digit seven-segment driver.
// Scans digits 0..3 every SCAN_DIV cycles (SCAN_DIV >= 16 so a conversion
// always finishes inside one slot), samples i_value once per frame, converts
// it to BCD in the background and swaps the shown digits only when the
// conversion completes. Leading-zero blanking and dots are applied live.
//   clk, reset  : clock, synchronous active-high reset
//   i_value     : binary value 0..9999 (larger saturates to 9999)
//   i_blank_lz  : blank leading zeros
//   i_dp_mask   : per-digit dot enable, bit k = digit k
//   i_dp_blink  : enabled dots follow o_dot_pls instead of steady on
//   o_fndcom    : digit enables, active-low one-cold (registered)
//   o_fndfont   : segments, active-low, bit7 = dp (registered)
//   o_dot_pls   : blink phase, toggles every BLINK_DIV cycles
module fnd_scan
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
  parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] i_value,
  input  logic        i_blank_lz,
  input  logic [3:0]  i_dp_mask,
  input  logic        i_dp_blink,
  output logic [3:0]  o_fndcom,
  output logic [7:0]  o_fndfont,
  output logic        o_dot_pls
);

  localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          dot_q, dot_d;
  logic          first_q, first_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    com_q, com_d;
  logic [7:0]    font_q, font_d;

  logic          scan_tick, blink_tick, frame_req;
  logic          conv_busy, conv_done;
  logic [13:0]   conv_bin;
  logic [15:0]   conv_bcd;
  logic [3:0]    cur_dig;
  logic          lz3, lz2, lz1, blank;

  // Frame start: wrap from digit 3 back to 0, or the first cycle out of reset
  assign frame_req = first_q | (scan_tick & (idx_q == 2'd3));
  assign conv_bin  = (i_value > 14'd9999) ? 14'd9999 : i_value;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (frame_req & ~conv_busy),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    scan_tick   = (scan_cnt_q == SW'(SCAN_DIV - 1));
    scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + 1'b1;
    idx_d       = scan_tick ? idx_q + 2'd1 : idx_q;

    blink_tick  = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d = blink_tick ? '0 : blink_cnt_q + 1'b1;
    dot_d       = dot_q ^ blink_tick;

    first_d = 1'b0;
    disp_d  = conv_done ? conv_bcd : disp_q;

    // A digit is a leading zero when it and every higher digit are zero
    lz3 = (disp_q[15:12] == 4'd0);
    lz2 = lz3 & (disp_q[11:8] == 4'd0);
    lz1 = lz2 & (disp_q[7:4]  == 4'd0);

    case (idx_q)
      2'd0:    begin cur_dig = disp_q[3:0];   blank = 1'b0;              end
      2'd1:    begin cur_dig = disp_q[7:4];   blank = i_blank_lz & lz1;  end
      2'd2:    begin cur_dig = disp_q[11:8];  blank = i_blank_lz & lz2;  end
      default: begin cur_dig = disp_q[15:12]; blank = i_blank_lz & lz3;  end
    endcase

    com_d  = com_code(idx_q);
    font_d = blank ? FONT_BLANK : seg_font(cur_dig);
    if (i_dp_mask[idx_q] && (!i_dp_blink || dot_q)) font_d[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      idx_q       <= '0;
      dot_q       <= 1'b0;
      first_q     <= 1'b1;
      disp_q      <= '0;
      com_q       <= COM_OFF;
      font_q      <= FONT_BLANK;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      idx_q       <= idx_d;
      dot_q       <= dot_d;
      first_q     <= first_d;
      disp_q      <= disp_d;
      com_q       <= com_d;
      font_q      <= font_d;
    end
  end

  assign o_fndcom  = com_q;
  assign o_fndfont = font_q;
  assign o_dot_pls = dot_q;

endmodule

// File: doc/fnd_scan.md
FND_SCAN -- requirements
Module: fnd_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100_000, meaning clock cycles per digit slot (minimum 16).
REQ-002 SHALL have parameter BLINK_DIV, default 50_000_000, meaning clock cycles per half-period of the dot blink.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_value  input  14  binary value to display, 0..9999.
REQ-006 SHALL have port i_blank_lz  input  1  1 = blank leading zeros.
REQ-007 SHALL have port i_dp_mask  input  4  per-digit decimal-point enable; bit k = digit k, with digit 0 = ones.
REQ-008 SHALL have port i_dp_blink  input  1  1 = enabled dots follow o_dot_pls; 0 = enabled dots are steady on.
REQ-009 SHALL have port o_fndcom  output  4  digit enables, active-low, one-cold.
REQ-010 SHALL have port o_fndfont  output  8  segments, active-low; bit7 = dp, bits6..0 = g..a.
REQ-011 SHALL have port o_dot_pls  output  1  blink phase square wave.

Function
REQ-012 SHALL count cycles 0..SCAN_DIV-1 and raise a one-cycle scan tick at SCAN_DIV-1, then wrap to 0.
REQ-013 SHALL advance the 2-bit digit index on each scan tick in the order 0,1,2,3,0.
REQ-014 SHALL define a frame start as the tick on which the index wraps from 3 to 0, plus the first cycle after reset release.
REQ-015 SHALL map the digit index to o_fndcom as: 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111.
REQ-016 SHALL sample i_value at each frame start; sampled values above 9999 SHALL saturate to 9999.
REQ-017 SHALL start a sequential double-dabble conversion on each frame start: 1 load cycle plus 14 shift/add-3 cycles, so done is asserted 15 cycles after start.
REQ-018 SHALL latch the four BCD digits only on the done cycle; the displayed digits SHALL stay unchanged while a conversion is in progress.
REQ-019 SHALL ignore a start request while busy (cannot occur because SCAN_DIV >= 16).
REQ-020 SHALL decode digits to fonts as: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF (hex, before the dp bit is applied).
REQ-021 SHALL, when i_blank_lz=1, blank digit k (k = 3..1) if digit k and all higher digits are zero; digit 0 is never blanked.
REQ-022 SHALL clear bit7 (dot on) for digit k when i_dp_mask[k] && (!i_dp_blink || o_dot_pls); a blanked digit with its dot on SHALL output 7F.
REQ-023 SHALL toggle o_dot_pls every BLINK_DIV cycles.
REQ-024 SHALL register o_fndcom and o_fndfont, updating them 1 cycle after an index or digit change.
REQ-025 SHALL read i_blank_lz, i_dp_mask and i_dp_blink live, not sampled per frame.

Reset
REQ-026 SHALL, when reset is asserted (including mid-frame or mid-conversion), on the next edge drive o_fndcom=4'b1111, o_fndfont=8'hFF, o_dot_pls=0.
REQ-027 SHALL, on reset, clear the scan counter, digit index, blink counter, latched BCD digits and converter state to 0/idle.
REQ-028 SHALL start a conversion on the first cycle after reset deassertion.

Structure
REQ-029 SHALL place the font constants, blank code, the o_fndcom codes and the default SCAN_DIV/BLINK_DIV values in the shared package fnd_pkg.
REQ-030 SHALL implement the converter as the sub-module bin2bcd_seq (ports: clk, reset, start, bin[13:0], busy, done, bcd[15:0]).

Verification (SCAN_DIV=16, BLINK_DIV=32)
REQ-031 SHALL verify: i_value=1234 after reset, one full frame -> com/font pairs 1110/99, 1101/B0, 1011/A4, 0111/F9.
REQ-032 SHALL verify: i_value=7 -> with i_blank_lz=1, digits 3..1 = FF and digit 0 = F8; with i_blank_lz=0, digits 3..1 = C0.
REQ-033 SHALL verify: i_value=12000 -> all four digits show 90.
REQ-034 SHALL verify: i_dp_mask=4'b0100, i_dp_blink=1 -> at com 1011, font bit7 = ~o_dot_pls, toggling every 32 cycles; with i_dp_blink=0, bit7 stays 0.
REQ-035 SHALL verify: i_value changes 1234 -> 5678 mid-frame -> the current frame still shows 1234, and the next frame shows 5678 from 15 cycles after frame start.
REQ-036 SHALL verify: reset pulsed during digit 2 with a conversion busy -> next cycle outputs 1111/FF/0, and after release the display restarts at index 0 with a fresh conversion.
